// File: rtl/layer_stream_arbiter.sv
// ----------------------------------------------------------------------------
// layer_stream_arbiter
//
// Shares one fully-connected layer instance between R requesters. A
// round-robin input FSM hands the layer's input stream to one requester for
// exactly one N-word vector. The owner of every vector is recorded in an
// in-order job FIFO, and each M-word output vector the layer produces is
// routed back to the requester at the FIFO head.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous reset, active low
//   s_valid     per-requester input valid            (R)
//   s_ready     per-requester input ready            (R)
//   s_data      per-requester input words, packed    (R*T), requester r at [r*T +: T]
//   m_valid     per-requester output valid           (R)
//   m_ready     per-requester output ready           (R)
//   m_data      shared output word                   (T), equals l_data_out
//   l_reset     layer reset, active high, = ~reset
//   l_s_valid   to layer s_valid
//   l_s_ready   from layer s_ready
//   l_data_in   to layer data_in                     (T)
//   l_m_valid   from layer m_valid
//   l_m_ready   to layer m_ready
//   l_data_out  from layer data_out                  (T)
//   busy        FSM in FEED or jobs still in flight
// ----------------------------------------------------------------------------
module layer_stream_arbiter #(
    parameter int T    = 20,
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int R    = 2,
    parameter int JOBQ = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   s_valid,
    output logic [R-1:0]   s_ready,
    input  logic [R*T-1:0] s_data,
    output logic [R-1:0]   m_valid,
    input  logic [R-1:0]   m_ready,
    output logic [T-1:0]   m_data,
    output logic           l_reset,
    output logic           l_s_valid,
    input  logic           l_s_ready,
    output logic [T-1:0]   l_data_in,
    input  logic           l_m_valid,
    output logic           l_m_ready,
    input  logic [T-1:0]   l_data_out,
    output logic           busy
);

    localparam int IW  = (R > 1) ? $clog2(R) : 1;
    localparam int ICW = $clog2(N) + 1;
    localparam int OCW = $clog2(M) + 1;
    localparam int PW  = (JOBQ > 1) ? $clog2(JOBQ) : 1;
    localparam int CW  = $clog2(JOBQ + 1);

    localparam logic [ICW-1:0] IN_LAST  = ICW'(N - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(M - 1);
    localparam logic [CW-1:0]  FIFO_MAX = CW'(JOBQ);
    localparam logic [PW-1:0]  PTR_LAST = PW'(JOBQ - 1);

    typedef enum logic {IDLE, FEED} state_t;

    state_t          state;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   last_grant;
    logic [ICW-1:0]  in_cnt;
    logic [OCW-1:0]  out_cnt;

    logic [IW-1:0]   fifo_mem [JOBQ];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   fifo_cnt;

    logic [IW-1:0]   win;
    logic            win_found;
    logic [IW-1:0]   head;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            in_hs;
    logic            out_hs;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting just after the last completed owner.
    always_comb begin
        int idx;
        idx       = 0;
        win       = last_grant;
        win_found = 1'b0;
        for (int i = 1; i <= R; i++) begin
            idx = (int'(last_grant) + i) % R;
            if (!win_found && s_valid[idx]) begin
                win       = IW'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];

    // Uses the registered count only: a pop in this same cycle frees its slot
    // for the grant decision of the next cycle.
    assign push   = (state == IDLE) && win_found && (fifo_cnt < FIFO_MAX);
    assign in_hs  = l_s_valid && l_s_ready;
    assign out_hs = l_m_valid && l_m_ready;
    assign pop    = out_hs && (out_cnt == OUT_LAST);

    // Input side: pure pass-through from the granted requester.
    always_comb begin
        s_ready   = '0;
        l_s_valid = 1'b0;
        l_data_in = s_data[int'(gnt)*T +: T];
        if (state == FEED) begin
            l_s_valid    = s_valid[gnt];
            s_ready[gnt] = l_s_ready;
        end
    end

    // Output side: FIFO head owns the layer output; with no owner the layer
    // output is stalled rather than dropped.
    always_comb begin
        m_valid   = '0;
        l_m_ready = 1'b0;
        if (!fifo_empty) begin
            m_valid[head] = l_m_valid;
            l_m_ready     = m_ready[head];
        end
    end

    assign m_data  = l_data_out;
    assign l_reset = ~reset;
    assign busy    = (state == FEED) || !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gnt        <= '0;
            last_grant <= IW'(R - 1);
            in_cnt     <= '0;
            out_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        gnt    <= win;
                        in_cnt <= '0;
                        state  <= FEED;
                    end
                end
                FEED: begin
                    // Grant stays locked until the full vector has moved,
                    // even if the owner's valid drops in the middle.
                    if (in_hs) begin
                        if (in_cnt == IN_LAST) begin
                            last_grant <= gnt;
                            in_cnt     <= '0;
                            state      <= IDLE;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end

            if (pop) begin
                rd_ptr  <= ptr_next(rd_ptr);
                out_cnt <= '0;
            end else if (out_hs) begin
                out_cnt <= out_cnt + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Owner storage is plain data; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= win;
        end
    end

endmodule

// File: tb/tb_layer_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_layer_stream_arbiter
//
// Drives R requesters and a simple behavioural layer (collects N words, then
// emits M words, each an XOR-transform of the matching input word). Expected
// per-requester output streams are derived from what each requester handed
// over, and every delivered output word is checked against them in order.
// ----------------------------------------------------------------------------
module tb_layer_stream_arbiter;
    localparam int T    = 20;
    localparam int N    = 8;
    localparam int M    = 8;
    localparam int R    = 2;
    localparam int JOBQ = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [R-1:0]   s_valid = '0;
    logic [R-1:0]   s_ready;
    logic [R*T-1:0] s_data = '0;
    logic [R-1:0]   m_valid;
    logic [R-1:0]   m_ready = '0;
    logic [T-1:0]   m_data;
    logic           l_reset;
    logic           l_s_valid;
    logic           l_s_ready = 1'b0;
    logic [T-1:0]   l_data_in;
    logic           l_m_valid = 1'b0;
    logic           l_m_ready;
    logic [T-1:0]   l_data_out = '0;
    logic           busy;

    layer_stream_arbiter #(.T(T), .N(N), .M(M), .R(R), .JOBQ(JOBQ)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .l_reset(l_reset), .l_s_valid(l_s_valid), .l_s_ready(l_s_ready),
        .l_data_in(l_data_in), .l_m_valid(l_m_valid), .l_m_ready(l_m_ready),
        .l_data_out(l_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [T-1:0] exp_q   [R][$];
    logic [T-1:0] req_buf [R][$];
    logic [T-1:0] lin_buf [$];
    logic [T-1:0] layer_q [$];
    int           owner_log [$];
    int           recv [R];
    logic [T-1:0] first_out [R];
    bit           got_first [R];
    bit           acc_s [R];
    int           out_total;
    bit           any_s, any_m;

    // Stimulus state
    int widx [R];
    int vidx [R];
    int rem  [R];
    bit en   [R];
    bit pause0, rnd, stall;

    function automatic logic [T-1:0] enc(input int r, input int v, input int k);
        return {r[3:0], v[11:0], k[3:0]};
    endfunction

    function automatic logic [T-1:0] xform(input logic [T-1:0] w);
        return w ^ 20'h5A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Compare process: outputs are stable mid-cycle; handshakes seen here are
    // the ones the next rising edge will commit.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_outputs", 32'({s_ready, m_valid, l_s_valid, l_m_ready, busy, l_reset}), 32'd1);
            for (int r = 0; r < R; r++) acc_s[r] = 1'b0;
        end else begin
            check("l_reset_low", 32'(l_reset), 32'd0);
            check("s_ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
            check("m_valid_onehot", 32'($countones(m_valid) <= 1), 32'd1);
            check("m_data_passthru", 32'(m_data), 32'(l_data_out));
            any_s = |(s_valid & s_ready);
            any_m = |(m_valid & m_ready);
            check("in_hs_match", 32'(any_s), 32'(l_s_valid && l_s_ready));
            check("out_hs_match", 32'(any_m), 32'(l_m_valid && l_m_ready));

            for (int r = 0; r < R; r++) begin
                acc_s[r] = s_valid[r] && s_ready[r];
                if (acc_s[r]) begin
                    check($sformatf("l_data_in_r%0d", r), 32'(l_data_in), 32'(s_data[r*T +: T]));
                    if (req_buf[r].size() == 0) owner_log.push_back(r);
                    req_buf[r].push_back(s_data[r*T +: T]);
                    if (req_buf[r].size() == N) begin
                        for (int k = 0; k < M; k++) exp_q[r].push_back(xform(req_buf[r][k % N]));
                        req_buf[r].delete();
                    end
                end
            end

            if (l_s_valid && l_s_ready) begin
                lin_buf.push_back(l_data_in);
                if (lin_buf.size() == N) begin
                    for (int k = 0; k < M; k++) layer_q.push_back(xform(lin_buf[k % N]));
                    lin_buf.delete();
                end
            end

            for (int r = 0; r < R; r++) begin
                if (m_valid[r] && m_ready[r]) begin
                    if (exp_q[r].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL out_unexpected_r%0d: got word %0h, required no output", r, m_data);
                    end else begin
                        check($sformatf("out_data_r%0d", r), 32'(m_data), 32'(exp_q[r].pop_front()));
                    end
                    if (!got_first[r]) begin
                        first_out[r] = m_data;
                        got_first[r] = 1'b1;
                    end
                    recv[r]++;
                    out_total++;
                end
            end

            if (l_m_valid && l_m_ready && layer_q.size() > 0) void'(layer_q.pop_front());
        end
    end

    task automatic drive();
        for (int r = 0; r < R; r++) begin
            if (acc_s[r]) begin
                widx[r]++;
                if (widx[r] == N) begin
                    widx[r] = 0;
                    vidx[r]++;
                    rem[r]--;
                end
            end
            s_valid[r] = en[r] && (rem[r] > 0) && !(r == 0 && pause0 && widx[0] == 3)
                         && (!rnd || $urandom_range(7, 0) != 0);
            s_data[r*T +: T] = enc(r, vidx[r], widx[r]);
            m_ready[r] = !rnd || ($urandom_range(7, 0) != 0);
        end
        l_s_ready  = !rnd || ($urandom_range(7, 0) != 0);
        l_m_valid  = !stall && (layer_q.size() > 0) && (!rnd || $urandom_range(7, 0) != 0);
        l_data_out = (layer_q.size() > 0) ? layer_q[0] : '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_model();
        for (int r = 0; r < R; r++) begin
            exp_q[r].delete();
            req_buf[r].delete();
            recv[r] = 0;
            got_first[r] = 1'b0;
            first_out[r] = '0;
            acc_s[r] = 1'b0;
            widx[r] = 0;
            vidx[r] = 0;
            rem[r] = 0;
            en[r] = 1'b0;
        end
        lin_buf.delete();
        layer_q.delete();
        owner_log.delete();
        out_total = 0;
        pause0 = 1'b0;
        rnd = 1'b0;
        stall = 1'b0;
        s_valid = '0;
        s_data = '0;
        m_ready = '0;
        l_s_ready = 1'b0;
        l_m_valid = 1'b0;
        l_data_out = '0;
    endtask

    // Reset is asserted between clock edges and its effect checked before
    // any further edge.
    task automatic do_reset(input bit wait_edge);
        if (wait_edge) begin
            @(posedge clk);
            #2;
        end else begin
            #1;
        end
        reset = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_l_s_valid", 32'(l_s_valid), 32'd0);
        check("rst_l_m_ready", 32'(l_m_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_l_reset", 32'(l_reset), 32'd1);
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    function automatic bit all_done();
        for (int r = 0; r < R; r++) begin
            if (rem[r] != 0 || exp_q[r].size() != 0) return 1'b0;
        end
        return (busy == 1'b0) && (layer_q.size() == 0);
    endfunction

    task automatic run_until_idle(input string name, input int maxc);
        int c;
        c = 0;
        while (!all_done()) begin
            if (c >= maxc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, c);
                return;
            end
            cyc();
            #1;
            c++;
        end
    endtask

    task automatic check_owners(input string name, input int want[$]);
        check({name, "_count"}, 32'(owner_log.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < owner_log.size(); i++)
            check($sformatf("%s_%0d", name, i), 32'(owner_log[i]), 32'(want[i]));
    endtask

    task automatic wait_word3(input string name);
        int c;
        c = 0;
        while (widx[0] != 3) begin
            if (c >= 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_timeout: requester 0 at word %0d, required 3", name, widx[0]);
                return;
            end
            cyc();
            c++;
        end
    endtask

    initial begin
        int k, first;
        bit ok;

        // Single vector from requester 0
        do_reset(1'b1);
        en[0] = 1'b1;
        rem[0] = 1;
        cyc();
        #1;
        check("t1_grant_cycle_ready", 32'(s_ready), 32'd0);
        check("t1_grant_cycle_lvalid", 32'(l_s_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
            cyc();
            #1;
            check($sformatf("t1_ready_w%0d", i), 32'(s_ready), 32'd1);
            check($sformatf("t1_data_w%0d", i), 32'(l_data_in), 32'(i));
        end
        cyc();
        #1;
        check("t1_ready_after", 32'(s_ready), 32'd0);
        run_until_idle("t1", 200);
        check("t1_recv0", 32'(recv[0]), 32'd8);
        check("t1_recv1", 32'(recv[1]), 32'd0);
        check("t1_first_out", 32'(first_out[0]), 32'h5A5A5);
        check("t1_busy_low", 32'(busy), 32'd0);

        // Round-robin, no backpressure
        do_reset(1'b1);
        en[0] = 1'b1; en[1] = 1'b1;
        rem[0] = 2; rem[1] = 2;
        run_until_idle("t2", 400);
        check_owners("t2_owner", '{0, 1, 0, 1});
        check("t2_recv0", 32'(recv[0]), 32'd16);
        check("t2_recv1", 32'(recv[1]), 32'd16);
        check("t2_first_out1", 32'(first_out[1]), 32'h4A5A5);

        // Job FIFO full while the layer output is stalled
        do_reset(1'b1);
        stall = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        rem[0] = 4; rem[1] = 4;
        repeat (50) cyc();
        #1;
        check("t3_grants_when_full", 32'(owner_log.size()), 32'd4);
        ok = 1'b1;
        repeat (10) begin
            cyc();
            #1;
            if (s_ready != '0) ok = 1'b0;
        end
        check("t3_no_ready_when_full", 32'(ok), 32'd1);
        check("t3_busy_full", 32'(busy), 32'd1);
        out_total = 0;
        stall = 1'b0;
        k = -1;
        first = -1;
        for (int i = 0; i < 200 && first < 0; i++) begin
            cyc();
            #1;
            if (k < 0 && out_total >= 8) k = i;
            if (k >= 0 && first < 0 && s_ready != '0) first = i;
        end
        check("t3_fifth_grant_timing", 32'(first), 32'(k + 1));
        run_until_idle("t3", 600);
        check_owners("t3_owner", '{0, 1, 0, 1, 0, 1, 0, 1});
        check("t3_recv0", 32'(recv[0]), 32'd32);
        check("t3_recv1", 32'(recv[1]), 32'd32);

        // Owner's valid drops mid-vector; the other requester must wait
        do_reset(1'b1);
        en[0] = 1'b1; en[1] = 1'b1;
        rem[0] = 1; rem[1] = 1;
        pause0 = 1'b1;
        wait_word3("t4");
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            check($sformatf("t4_hold_ready1_%0d", i), 32'(s_ready[1]), 32'd0);
            check($sformatf("t4_hold_lvalid_%0d", i), 32'(l_s_valid), 32'd0);
        end
        pause0 = 1'b0;
        run_until_idle("t4", 300);
        check_owners("t4_owner", '{0, 1});
        check("t4_recv0", 32'(recv[0]), 32'd8);
        check("t4_recv1", 32'(recv[1]), 32'd8);

        // Asynchronous reset in the middle of a vector
        do_reset(1'b1);
        en[0] = 1'b1; en[1] = 1'b1;
        rem[0] = 2; rem[1] = 2;
        wait_word3("t5");
        check("t5_busy_before", 32'(busy), 32'd1);
        check("t5_feeding_before", 32'(l_s_valid), 32'd1);
        do_reset(1'b0);
        en[0] = 1'b1; en[1] = 1'b1;
        rem[0] = 1; rem[1] = 1;
        run_until_idle("t5", 300);
        check_owners("t5_owner", '{0, 1});
        check("t5_recv0", 32'(recv[0]), 32'd8);
        check("t5_recv1", 32'(recv[1]), 32'd8);
        check("t5_first_out", 32'(first_out[0]), 32'h5A5A5);

        // Randomised traffic and backpressure over 1000 vectors
        do_reset(1'b1);
        rnd = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        rem[0] = 500; rem[1] = 500;
        run_until_idle("t6", 60000);
        check("t6_vectors", 32'(owner_log.size()), 32'd1000);
        check("t6_recv0", 32'(recv[0]), 32'd4000);
        check("t6_recv1", 32'(recv[1]), 32'd4000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
